// File: rtl/shots_pkg.sv
// Shared definitions for the multi-shot controller and the draw engine:
// scan state encoding, coordinate widths and draw-op encoding.
package shots_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam logic DRAW_OP  = 1'b0;
    localparam logic ERASE_OP = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ERASE,
        MOVE,
        DRAW,
        SPAWN
    } scan_state_t;

endpackage

// File: rtl/multi_shot_controller_if.sv
// Valid/ready request channel from the shot controller to the shared VGA draw engine.
interface multi_shot_controller_if;
    import shots_pkg::*;

    logic           drawValid;
    logic           drawErase;
    logic [X_W-1:0] drawX;
    logic [Y_W-1:0] drawY;
    logic           drawReady;

    modport master (output drawValid, drawErase, drawX, drawY, input drawReady);
    modport slave  (input drawValid, drawErase, drawX, drawY, output drawReady);

endinterface

// File: rtl/lowest_free_slot.sv
// Priority encoder returning the lowest-index unoccupied shot slot.
module lowest_free_slot #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     occupied,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    // Scanning downwards lets the lowest free index overwrite any higher one.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_shot_controller.sv
// Frame-driven manager for several concurrent player shots: moves, retires and
// spawns shots, issuing erase/draw requests to the shared draw engine.
module multi_shot_controller
    import shots_pkg::*;
#(
    parameter int NUM_SHOTS = 4,
    parameter int SHOT_STEP = 2,
    parameter int Y_TOP     = 0,
    parameter int COOLDOWN  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frameTick,
    input  logic                     fireKey,
    input  logic [X_W-1:0]           rocketX,
    input  logic [Y_W-1:0]           rocketY,
    input  logic [NUM_SHOTS-1:0]     collidedWithAlien,
    multi_shot_controller_if.master  draw,
    output logic [NUM_SHOTS-1:0]     shotActive,
    output logic [NUM_SHOTS*X_W-1:0] shotX,
    output logic [NUM_SHOTS*Y_W-1:0] shotY,
    output logic [NUM_SHOTS-1:0]     retireTop,
    output logic [NUM_SHOTS-1:0]     retireHit,
    output logic                     shotDropped,
    output logic                     busy
);

    localparam int IDX_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SHOTS - 1);
    localparam logic [Y_W:0]     Y_LIMIT  = (Y_W + 1)'(Y_TOP + SHOT_STEP);

    scan_state_t      state, state_next, adv_state;
    logic [IDX_W-1:0] idx, idx_next, adv_idx;
    logic [X_W-1:0]   slot_x [NUM_SHOTS];
    logic [Y_W-1:0]   slot_y [NUM_SHOTS];
    logic [NUM_SHOTS-1:0] hit_latch;
    logic [CD_W-1:0]  cooldown;
    logic             fire_pending, fire_prev;
    logic             draw_valid, draw_erase;
    logic [X_W-1:0]   draw_x;
    logic [Y_W-1:0]   draw_y;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic [Y_W-1:0]   moved_y;
    logic             handshake;
    logic             start_erase, move_en, retire_hit_en, retire_top_en;
    logic             spawn_en, drop_en, clear_valid;

    lowest_free_slot #(.N(NUM_SHOTS), .IDX_W(IDX_W)) u_free (
        .occupied (shotActive),
        .index    (free_idx),
        .found    (free_found)
    );

    assign handshake = draw_valid & draw.drawReady;
    assign moved_y   = slot_y[idx] - Y_W'(SHOT_STEP);
    assign busy      = (state != IDLE);

    assign draw.drawValid = draw_valid;
    assign draw.drawErase = draw_erase;
    assign draw.drawX     = draw_x;
    assign draw.drawY     = draw_y;

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_flat
        assign shotX[g*X_W +: X_W] = slot_x[g];
        assign shotY[g*Y_W +: Y_W] = slot_y[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Retiring and finishing a draw both move on exactly like an inactive slot in CHECK.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        adv_state     = (idx == LAST_IDX) ? SPAWN : CHECK;
        adv_idx       = (idx == LAST_IDX) ? idx : idx + IDX_W'(1);
        start_erase   = 1'b0;
        move_en       = 1'b0;
        retire_hit_en = 1'b0;
        retire_top_en = 1'b0;
        spawn_en      = 1'b0;
        drop_en       = 1'b0;
        clear_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (frameTick) begin
                    state_next = CHECK;
                    idx_next   = '0;
                end
            end
            CHECK: begin
                if (shotActive[idx]) begin
                    state_next  = ERASE;
                    start_erase = 1'b1;
                end else begin
                    state_next = adv_state;
                    idx_next   = adv_idx;
                end
            end
            ERASE: begin
                if (handshake) begin
                    state_next  = MOVE;
                    clear_valid = 1'b1;
                end
            end
            MOVE: begin
                if (hit_latch[idx]) begin
                    retire_hit_en = 1'b1;
                    state_next    = adv_state;
                    idx_next      = adv_idx;
                end else if ({1'b0, slot_y[idx]} < Y_LIMIT) begin
                    retire_top_en = 1'b1;
                    state_next    = adv_state;
                    idx_next      = adv_idx;
                end else begin
                    move_en    = 1'b1;
                    state_next = DRAW;
                end
            end
            DRAW: begin
                if (handshake) begin
                    clear_valid = 1'b1;
                    state_next  = adv_state;
                    idx_next    = adv_idx;
                end
            end
            SPAWN: begin
                if (draw_valid) begin
                    if (handshake) begin
                        clear_valid = 1'b1;
                        state_next  = IDLE;
                    end
                end else if (fire_pending && free_found) begin
                    spawn_en = 1'b1;
                end else begin
                    drop_en    = fire_pending;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Slot storage, fire/cooldown bookkeeping and hit latches; later assignments win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shotActive   <= '0;
            hit_latch    <= '0;
            retireTop    <= '0;
            retireHit    <= '0;
            shotDropped  <= 1'b0;
            cooldown     <= '0;
            fire_pending <= 1'b0;
            fire_prev    <= 1'b0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
        end else begin
            fire_prev   <= fireKey;
            retireTop   <= '0;
            retireHit   <= '0;
            shotDropped <= drop_en;
            hit_latch   <= hit_latch | (collidedWithAlien & shotActive);
            if (fireKey && !fire_prev && cooldown == '0) begin
                fire_pending <= 1'b1;
            end
            if (spawn_en || drop_en) begin
                fire_pending <= 1'b0;
            end
            if (spawn_en) begin
                cooldown <= CD_W'(COOLDOWN);
            end else if (frameTick && cooldown != '0) begin
                cooldown <= cooldown - CD_W'(1);
            end
            if (retire_hit_en || retire_top_en) begin
                shotActive[idx] <= 1'b0;
                hit_latch[idx]  <= 1'b0;
                retireHit[idx]  <= retire_hit_en;
                retireTop[idx]  <= retire_top_en;
            end
            if (move_en) begin
                slot_y[idx] <= moved_y;
            end
            if (spawn_en) begin
                shotActive[free_idx] <= 1'b1;
                slot_x[free_idx]     <= rocketX;
                slot_y[free_idx]     <= rocketY;
            end
        end
    end

    // Request registers only change when idle or on the handshake, so they hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            draw_valid <= 1'b0;
            draw_erase <= DRAW_OP;
            draw_x     <= '0;
            draw_y     <= '0;
        end else if (start_erase) begin
            draw_valid <= 1'b1;
            draw_erase <= ERASE_OP;
            draw_x     <= slot_x[idx];
            draw_y     <= slot_y[idx];
        end else if (move_en) begin
            draw_valid <= 1'b1;
            draw_erase <= DRAW_OP;
            draw_x     <= slot_x[idx];
            draw_y     <= moved_y;
        end else if (spawn_en) begin
            draw_valid <= 1'b1;
            draw_erase <= DRAW_OP;
            draw_x     <= rocketX;
            draw_y     <= rocketY;
        end else if (clear_valid) begin
            draw_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_shot_controller.sv
// Scoreboard bench for multi_shot_controller: expected draw/retire/drop events are
// queued by the stimulus and popped by a monitor as the DUT produces them.
module tb_multi_shot_controller;
    import shots_pkg::*;

    localparam logic [1:0] K_DRAW = 2'd0;
    localparam logic [1:0] K_TOP  = 2'd1;
    localparam logic [1:0] K_HIT  = 2'd2;
    localparam logic [1:0] K_DROP = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic       erase;
        logic [7:0] x;
        logic [6:0] y;
        logic [3:0] mask;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        frameTick;
    logic        fireKey;
    logic [7:0]  rocketX;
    logic [6:0]  rocketY;
    logic [3:0]  collidedWithAlien;
    logic [3:0]  shotActive;
    logic [31:0] shotX;
    logic [27:0] shotY;
    logic [3:0]  retireTop;
    logic [3:0]  retireHit;
    logic        shotDropped;
    logic        busy;

    ev_t  exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic       m_act [4];
    logic [7:0] m_x   [4];
    logic [6:0] m_y   [4];

    multi_shot_controller_if draw_bus ();

    multi_shot_controller dut (
        .clk               (clk),
        .reset             (reset),
        .frameTick         (frameTick),
        .fireKey           (fireKey),
        .rocketX           (rocketX),
        .rocketY           (rocketY),
        .collidedWithAlien (collidedWithAlien),
        .draw              (draw_bus),
        .shotActive        (shotActive),
        .shotX             (shotX),
        .shotY             (shotY),
        .retireTop         (retireTop),
        .retireHit         (retireHit),
        .shotDropped       (shotDropped),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk(input logic [1:0] k, input logic e, input logic [7:0] x,
                               input logic [6:0] y, input logic [3:0] m);
        ev_t r;
        r.kind  = k;
        r.erase = e;
        r.x     = x;
        r.y     = y;
        r.mask  = m;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic observe(input ev_t got);
        ev_t want;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_event: got kind=%0d erase=%0d x=%0d y=%0d mask=%b, expected none",
                     got.kind, got.erase, got.x, got.y, got.mask);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL event: got kind=%0d erase=%0d x=%0d y=%0d mask=%b, expected kind=%0d erase=%0d x=%0d y=%0d mask=%b",
                         got.kind, got.erase, got.x, got.y, got.mask,
                         want.kind, want.erase, want.x, want.y, want.mask);
            end
        end
    endtask

    // Monitor: every retire/drop pulse and every completed draw transfer is one event.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (|retireTop) observe(mk(K_TOP, 1'b0, 8'd0, 7'd0, retireTop));
            if (|retireHit) observe(mk(K_HIT, 1'b0, 8'd0, 7'd0, retireHit));
            if (shotDropped) observe(mk(K_DROP, 1'b0, 8'd0, 7'd0, 4'd0));
            if (draw_bus.drawValid && draw_bus.drawReady) begin
                observe(mk(K_DRAW, draw_bus.drawErase, draw_bus.drawX, draw_bus.drawY, 4'd0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 1'b0;
            m_x[i]   = 8'd0;
            m_y[i]   = 7'd0;
        end
    endtask

    task automatic pressFire(input logic [7:0] x, input logic [6:0] y);
        rocketX = x;
        rocketY = y;
        fireKey = 1'b1;
        tick();
        fireKey = 1'b0;
        tick();
    endtask

    // One frame's worth of expected traffic: erase, then retire or redraw 2 rows up.
    task automatic expectFrame(input logic [3:0] hit);
        for (int i = 0; i < 4; i++) begin
            if (m_act[i]) begin
                exp_q.push_back(mk(K_DRAW, ERASE_OP, m_x[i], m_y[i], 4'd0));
                if (hit[i]) begin
                    exp_q.push_back(mk(K_HIT, 1'b0, 8'd0, 7'd0, 4'(1 << i)));
                    m_act[i] = 1'b0;
                end else if (m_y[i] < 7'd2) begin
                    exp_q.push_back(mk(K_TOP, 1'b0, 8'd0, 7'd0, 4'(1 << i)));
                    m_act[i] = 1'b0;
                end else begin
                    m_y[i] = m_y[i] - 7'd2;
                    exp_q.push_back(mk(K_DRAW, DRAW_OP, m_x[i], m_y[i], 4'd0));
                end
            end
        end
    endtask

    task automatic expectSpawn(input logic [7:0] x, input logic [6:0] y);
        int slot = -1;
        for (int i = 3; i >= 0; i--) if (!m_act[i]) slot = i;
        if (slot < 0) begin
            exp_q.push_back(mk(K_DROP, 1'b0, 8'd0, 7'd0, 4'd0));
        end else begin
            m_act[slot] = 1'b1;
            m_x[slot]   = x;
            m_y[slot]   = y;
            exp_q.push_back(mk(K_DRAW, DRAW_OP, x, y, 4'd0));
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus();
        frameTick = 1'b1;
        tick();
        frameTick = 1'b0;
        waitIdle("frame_done");
    endtask

    task automatic runFrame(input logic [3:0] hit, input logic spawning);
        expectFrame(hit);
        if (spawning) expectSpawn(rocketX, rocketY);
        applyStimulus();
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        while (!draw_bus.drawValid && n < 50) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(draw_bus.drawValid), 32'd1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clearModel();
        tick();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        frameTick          = 1'b0;
        fireKey            = 1'b0;
        rocketX            = 8'd0;
        rocketY            = 7'd0;
        collidedWithAlien  = 4'd0;
        draw_bus.drawReady = 1'b1;
        clearModel();
        repeat (3) tick();
        checkOutput("rst_drawValid", 32'(draw_bus.drawValid), 32'd0);
        checkOutput("rst_shotActive", 32'(shotActive), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_shotX", shotX, 32'd0);
        reset = 1'b0;
        tick();

        // Spawn at (40,100), then watch it climb; a fire edge during cooldown is ignored.
        pressFire(8'd40, 7'd100);
        runFrame(4'b0000, 1'b1);
        checkOutput("spawn_active", 32'(shotActive), 32'b0001);
        checkOutput("spawn_x", 32'(shotX[7:0]), 32'd40);
        checkOutput("spawn_y", 32'(shotY[6:0]), 32'd100);
        runFrame(4'b0000, 1'b0);
        checkOutput("move_y", 32'(shotY[6:0]), 32'd98);
        runFrame(4'b0000, 1'b0);
        pressFire(8'd40, 7'd100);
        runFrame(4'b0000, 1'b0);
        checkOutput("cooldown_ignore", 32'(shotActive), 32'b0001);
        repeat (5) runFrame(4'b0000, 1'b0);

        pressFire(8'd60, 7'd50);
        runFrame(4'b0000, 1'b1);
        checkOutput("second_spawn", 32'(shotActive), 32'b0011);
        repeat (8) runFrame(4'b0000, 1'b0);
        pressFire(8'd80, 7'd70);
        runFrame(4'b0000, 1'b1);
        checkOutput("third_spawn", 32'(shotActive), 32'b0111);

        // Collision on slot 2 retires it; the others keep moving.
        collidedWithAlien = 4'b0100;
        tick();
        collidedWithAlien = 4'b0000;
        runFrame(4'b0100, 1'b0);
        checkOutput("hit_active", 32'(shotActive), 32'b0011);
        checkOutput("hit_slot0_y", 32'(shotY[6:0]), 32'd62);
        checkOutput("hit_slot1_y", 32'(shotY[13:7]), 32'd30);

        // Shot spawned low reaches the top: 5 -> 3 -> 1 -> retired.
        repeat (7) runFrame(4'b0000, 1'b0);
        pressFire(8'd10, 7'd5);
        runFrame(4'b0000, 1'b1);
        runFrame(4'b0000, 1'b0);
        runFrame(4'b0000, 1'b0);
        runFrame(4'b0000, 1'b0);
        checkOutput("top_active", 32'(shotActive), 32'b0011);
        checkOutput("top_slot1_y", 32'(shotY[13:7]), 32'd8);

        // Backpressure during the erase of slot 0 at (40,40).
        draw_bus.drawReady = 1'b0;
        expectFrame(4'b0000);
        frameTick = 1'b1;
        tick();
        frameTick = 1'b0;
        waitValid("bp_valid");
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_hold_valid", 32'(draw_bus.drawValid), 32'd1);
            checkOutput("bp_hold_erase", 32'(draw_bus.drawErase), 32'd1);
            checkOutput("bp_hold_x", 32'(draw_bus.drawX), 32'd40);
            checkOutput("bp_hold_y", 32'(draw_bus.drawY), 32'd40);
            tick();
        end
        draw_bus.drawReady = 1'b1;
        tick();
        checkOutput("bp_advance", 32'(draw_bus.drawValid), 32'd0);
        waitIdle("bp_done");

        // Fill all four slots; a collision on the still-empty slot 3 must be ignored.
        doReset();
        pressFire(8'd20, 7'd120);
        runFrame(4'b0000, 1'b1);
        for (int k = 1; k < 4; k++) begin
            repeat (8) runFrame(4'b0000, 1'b0);
            if (k == 3) begin
                collidedWithAlien = 4'b1000;
                tick();
                collidedWithAlien = 4'b0000;
            end
            pressFire(8'(20 + 20 * k), 7'd120);
            runFrame(4'b0000, 1'b1);
        end
        checkOutput("full_active", 32'(shotActive), 32'b1111);
        repeat (8) runFrame(4'b0000, 1'b0);
        pressFire(8'd99, 7'd120);
        runFrame(4'b0000, 1'b1);
        checkOutput("drop_active", 32'(shotActive), 32'b1111);

        // Reset while a redraw of slot 0 is waiting for ready.
        draw_bus.drawReady = 1'b0;
        exp_q.push_back(mk(K_DRAW, ERASE_OP, m_x[0], m_y[0], 4'd0));
        frameTick = 1'b1;
        tick();
        frameTick = 1'b0;
        waitValid("mid_erase_valid");
        draw_bus.drawReady = 1'b1;
        tick();
        draw_bus.drawReady = 1'b0;
        waitValid("mid_draw_valid");
        checkOutput("mid_draw_phase", 32'(draw_bus.drawErase), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_drawValid", 32'(draw_bus.drawValid), 32'd0);
        checkOutput("async_shotActive", 32'(shotActive), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        clearModel();
        draw_bus.drawReady = 1'b1;
        tick();
        applyStimulus();
        checkOutput("post_reset_active", 32'(shotActive), 32'd0);
        repeat (3) tick();

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
